// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: execute stage with a single-cycle ALU and an iterative multiply/divide unit.
//
// Single-cycle ops are registered into the EX/MEM slot one edge after acceptance. MUL, MULHU,
// DIVU and REMU are latched at acceptance and take one radix-2 step per cycle for XLEN cycles.
// During that time ex_busy is high and upstream must hold its next instruction.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid, flush       ID/EX valid; synchronous kill of EX work
//   operandA, operandB    source operands
//   imm, alu_src          immediate; when alu_src is 1, imm replaces operandB
//   alu_op                operation select
//   id_ex_*               control fields and rd carried alongside the instruction
//   ex_busy               a multi-cycle op is in flight
//   ex_mem_*              registered EX/MEM slot: valid, result, overflow, rd, controls
module ex_stage_mdu #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [4:0]      alu_op,
  input  logic            id_ex_Memwrite,
  input  logic            id_ex_Memread,
  input  logic            id_ex_MemtoReg,
  input  logic            id_ex_Regwrite,
  input  logic [4:0]      id_ex_rd,
  output logic            ex_busy,
  output logic            ex_mem_valid,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic            ex_mem_overflow,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_Memwrite,
  output logic            ex_mem_Memread,
  output logic            ex_mem_MemtoReg,
  output logic            ex_mem_Regwrite
);

  localparam int unsigned CntW = SHW + 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] b_q;
  // hi: product high half / partial remainder; lo: multiplier / dividend shifting into quotient
  logic [XLEN-1:0] hi_q, lo_q;
  logic [3:0]      ctrl_q;
  logic [4:0]      rd_q;

  logic [XLEN-1:0] b_sel;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sum, diff;
  logic [XLEN-1:0] alu_res;
  logic            alu_ovf;
  logic            is_mdu;

  assign b_sel  = alu_src ? imm : operandB;
  assign shamt  = b_sel[SHW-1:0];
  assign sum    = operandA + b_sel;
  assign diff   = operandA - b_sel;
  assign is_mdu = (alu_op[4:2] == 3'b100);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      5'b00000: alu_res = operandA & b_sel;
      5'b00001: alu_res = operandA | b_sel;
      5'b00010: begin
        alu_res = sum;
        alu_ovf = (operandA[XLEN-1] == b_sel[XLEN-1]) && (sum[XLEN-1] != operandA[XLEN-1]);
      end
      5'b00011: alu_res = operandA << shamt;
      5'b00100: alu_res = operandA >> shamt;
      5'b00101: alu_res = $signed(operandA) >>> shamt;
      5'b00110: begin
        alu_res = diff;
        alu_ovf = (operandA[XLEN-1] != b_sel[XLEN-1]) && (diff[XLEN-1] != operandA[XLEN-1]);
      end
      5'b00111: alu_res = {{(XLEN-1){1'b0}}, operandA < b_sel};
      5'b01000: alu_res = {{(XLEN-1){1'b0}}, $signed(operandA) < $signed(b_sel)};
      5'b01001: alu_res = operandA ^ b_sel;
      5'b01010: alu_res = {{(XLEN-1){1'b0}}, operandA == b_sel};
      5'b01011: alu_res = {{(XLEN-1){1'b0}}, operandA != b_sel};
      default:  alu_res = '0;
    endcase
  end

  // One iteration of the MDU datapath.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   r_shift;
  logic [XLEN-1:0] r_sub;
  logic            r_ge;
  logic [XLEN-1:0] hi_n, lo_n, mdu_res;

  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
  assign r_shift = {hi_q, lo_q[XLEN-1]};
  assign r_ge    = (r_shift >= {1'b0, b_q});
  // When r_ge holds, the true difference is below b_q, so the low XLEN bits are exact.
  assign r_sub   = r_shift[XLEN-1:0] - b_q;

  always_comb begin
    if (!op_q[1]) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_n = r_ge ? r_sub : r_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], r_ge};
    end
    // MULHU and REMU take the high register, MUL and DIVU the low one.
    mdu_res = op_q[0] ? hi_n : lo_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      op_q              <= '0;
      b_q               <= '0;
      hi_q              <= '0;
      lo_q              <= '0;
      ctrl_q            <= '0;
      rd_q              <= '0;
      ex_busy           <= 1'b0;
      ex_mem_valid      <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_overflow   <= 1'b0;
      ex_mem_rd         <= '0;
      ex_mem_Memwrite   <= 1'b0;
      ex_mem_Memread    <= 1'b0;
      ex_mem_MemtoReg   <= 1'b0;
      ex_mem_Regwrite   <= 1'b0;
    end else if (flush) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      ex_busy         <= 1'b0;
      ex_mem_valid    <= 1'b0;
      ex_mem_Memwrite <= 1'b0;
      ex_mem_Memread  <= 1'b0;
      ex_mem_Regwrite <= 1'b0;
    end else if (state_q == StIdle) begin
      if (in_valid && is_mdu) begin
        state_q         <= StBusy;
        ex_busy         <= 1'b1;
        cnt_q           <= '0;
        op_q            <= alu_op[1:0];
        b_q             <= b_sel;
        hi_q            <= '0;
        lo_q            <= operandA;
        ctrl_q          <= {id_ex_Memwrite, id_ex_Memread, id_ex_MemtoReg, id_ex_Regwrite};
        rd_q            <= id_ex_rd;
        ex_mem_valid    <= 1'b0;
        ex_mem_Memwrite <= 1'b0;
        ex_mem_Memread  <= 1'b0;
        ex_mem_MemtoReg <= 1'b0;
        ex_mem_Regwrite <= 1'b0;
      end else if (in_valid) begin
        ex_mem_valid      <= 1'b1;
        ex_mem_alu_result <= alu_res;
        ex_mem_overflow   <= alu_ovf;
        ex_mem_rd         <= id_ex_rd;
        ex_mem_Memwrite   <= id_ex_Memwrite;
        ex_mem_Memread    <= id_ex_Memread;
        ex_mem_MemtoReg   <= id_ex_MemtoReg;
        ex_mem_Regwrite   <= id_ex_Regwrite;
      end else begin
        ex_mem_valid    <= 1'b0;
        ex_mem_Memwrite <= 1'b0;
        ex_mem_Memread  <= 1'b0;
        ex_mem_MemtoReg <= 1'b0;
        ex_mem_Regwrite <= 1'b0;
      end
    end else begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CntW'(1);
      if (cnt_q == CntW'(XLEN - 1)) begin
        state_q           <= StIdle;
        ex_busy           <= 1'b0;
        ex_mem_valid      <= 1'b1;
        ex_mem_alu_result <= mdu_res;
        ex_mem_overflow   <= 1'b0;
        ex_mem_rd         <= rd_q;
        {ex_mem_Memwrite, ex_mem_Memread, ex_mem_MemtoReg, ex_mem_Regwrite} <= ctrl_q;
      end
    end
  end

endmodule

// File: doc/ex_stage_mdu.md
EX_STAGE_MDU -- requirements
Module: ex_stage_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values are powers of 2 from 8 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width; it is derived and not overridden.
REQ-003 SHALL have ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ID/EX holds a valid instruction.
- flush  in  1  synchronous kill of EX work.
- operandA  in  XLEN  source A.
- operandB  in  XLEN  source B.
- imm  in  XLEN  immediate.
- alu_src  in  1  1 = use imm as B.
- alu_op  in  5  operation select.
- id_ex_Memwrite, id_ex_Memread, id_ex_MemtoReg, id_ex_Regwrite  in  1 each  control signals.
- id_ex_rd  in  5  destination register.
- ex_busy  out  1  multi-cycle op in progress; upstream holds.
- ex_mem_valid  out  1  EX/MEM entry valid.
- ex_mem_alu_result  out  XLEN  result.
- ex_mem_overflow  out  1  signed ADD/SUB overflow.
- ex_mem_rd  out  5  registered rd.
- ex_mem_Memwrite, ex_mem_Memread, ex_mem_MemtoReg, ex_mem_Regwrite  out  1 each  registered controls.

Function
REQ-004 SHALL set B = alu_src ? imm : operandB.
REQ-005 SHALL decode single-cycle alu_op values as:
- 00000 AND, 00001 OR, 00010 ADD, 00011 SLL, 00100 SRL, 00101 SRA, 00110 SUB, 00111 SLTU, 01000 SLT, 01001 XOR.
- 01010 EQ, result = {0..,A==B}.
- 01011 NE, result = {0..,A!=B}.
- Unlisted codes give result 0.
REQ-006 SHALL decode multi-cycle alu_op values as: 10000 MUL (low XLEN bits), 10001 MULHU (high XLEN bits, unsigned), 10010 DIVU, 10011 REMU.
REQ-007 SHALL use B[SHW-1:0] as the shift amount; SRA SHALL replicate A[XLEN-1].
REQ-008 SHALL set ex_mem_overflow only for ADD/SUB, when the operand signs imply a signed overflow; it is 0 for all other ops.
REQ-009 SHALL implement a state machine with states IDLE and BUSY, plus a counter of SHW+1 bits.
REQ-010 In IDLE, with in_valid=1, flush=0 and a single-cycle op, the block SHALL register the result and all controls into ex_mem_* at the next edge with ex_mem_valid=1 (latency 1).
REQ-011 In IDLE, with in_valid=1, flush=0 and an MDU op, the block SHALL latch A, B and the controls, clear the counter and enter BUSY. ex_mem_valid SHALL be 0 at that edge (bubble).
REQ-012 ex_busy SHALL equal (state==BUSY), registered, never combinational from inputs.
REQ-013 In BUSY, the block SHALL do exactly one shift-add (MUL*) or one restoring subtract-shift (DIV*/REM*) step per cycle; in_valid SHALL be ignored.
REQ-014 At the edge ending the XLEN-th BUSY cycle, the block SHALL write the MDU result and latched controls to ex_mem_* with ex_mem_valid=1 and return to IDLE. The result is therefore visible XLEN edges after the accept edge.
REQ-015 With divisor 0, DIVU SHALL give all-ones and REMU SHALL give the dividend, produced by the normal iterations with no special path and the same latency.
REQ-016 flush=1 at an edge SHALL clear ex_mem_valid, ex_mem_Regwrite and ex_mem_Memwrite, force IDLE, and discard any partial MDU state. flush SHALL override acceptance.
REQ-017 When in_valid=0 in IDLE, the next edge SHALL clear ex_mem_valid, ex_mem_Regwrite, ex_mem_Memwrite and ex_mem_Memread; other ex_mem_* fields are don't-care.
REQ-018 During BUSY cycles before completion, ex_mem_valid and all ex_mem control outputs SHALL be held at 0.

Reset
REQ-019 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, counter 0, ex_busy 0 and every ex_mem_* output 0, including mid-BUSY.
REQ-020 After rst_n rises, the first edge SHALL behave as in IDLE.

Verification
REQ-021 The bench (XLEN=64) SHALL cover:
- ADD, A=10, B=5, in_valid=1 -> next edge result=15, valid=1, overflow=0; SUB gives 5; SLL gives 320; SLT gives 0.
- ADD, A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> result 64'h8000_0000_0000_0000, overflow=1.
- MUL 7*6, with ADD 1+1 held behind it -> ex_busy=1 for 64 cycles, result 42 with valid exactly 64 edges after accept, ADD result 2 one edge later; MULHU of all-ones*2 -> 1.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 64'hFFFF_FFFF_FFFF_FFFF; REMU 9/0 -> 9.
- flush at busy cycle 10 of a DIVU -> ex_busy=0 and valid=0 next edge, no result ever emitted.
- rst_n low at busy cycle 5 -> all outputs 0 asynchronously; after release, an ADD completes normally.
